// File: rtl/levenshtein_pkg.sv
// levenshtein_pkg
//   Shared definitions for the accelerator's serial-SRAM path. It holds the
//   SPI opcodes of the 23LC1024-class SRAM, the "no device" chip-select code,
//   the responder FSM state type and a helper that builds the 40-bit SPI
//   frame {cmd, addr[23:0], data}.
package levenshtein_pkg;

  localparam int WB_DATA_WIDTH = 8;
  localparam int SPI_ADDR_BITS = 24;
  localparam int FRAME_BITS    = 40;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam logic [1:0] SRAM_CFG_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Reads shift out a dummy zero byte while the SRAM returns its data byte.
  function automatic logic [FRAME_BITS-1:0] spi_frame(
    input logic                     we,
    input logic [SPI_ADDR_BITS-1:0] adr,
    input logic [WB_DATA_WIDTH-1:0] wdat
  );
    logic [7:0]               cmd;
    logic [WB_DATA_WIDTH-1:0] payload;
    cmd     = we ? SPI_CMD_WRITE : SPI_CMD_READ;
    payload = we ? wdat : '0;
    return {cmd, adr, payload};
  endfunction

endpackage

// File: rtl/spi_sram_responder_shift_engine.sv
// spi_shift_engine
//   Serialises one 40-bit SPI mode-0 frame, MSB first, at clk_i/2.
//   Each bit takes two clk_i cycles: phase 0 drives sck low with the bit on
//   mosi, phase 1 drives sck high; at the end of phase 1 the shift register
//   advances and miso is captured (the SRAM changes miso on the falling edge,
//   so it is stable for the whole high phase).
//
// Ports
//   clk_i, rst_ni  clock, synchronous active-low reset (control only)
//   i_start        1-cycle pulse: load i_frame and begin shifting
//   i_frame        40-bit frame to transmit
//   o_busy         high from the cycle after i_start until the frame ends
//   o_done         high during the final sck-high cycle of the frame;
//                  o_rx_byte is valid in that same cycle
//   o_sck, o_mosi  registered SPI clock and data out
//   i_miso         serial data in
//   o_rx_byte      last 8 bits received, including the bit sampled this cycle
module spi_shift_engine
  import levenshtein_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_frame,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sck,
  output logic                  o_mosi,
  input  logic                  i_miso,
  output logic [7:0]            o_rx_byte
);

  logic                  r_busy;
  logic                  r_phase;
  logic [5:0]            r_bit;
  logic                  r_sck;
  logic                  r_mosi;
  logic [FRAME_BITS-1:0] r_shreg;
  // Only seven bits of history are kept: the eighth received bit is the
  // live miso value in the final cycle, so the byte can be handed to the
  // parent in the same cycle the frame ends.
  logic [6:0]            r_rx_hist;
  logic                  w_last;

  assign w_last = r_busy & r_phase & (r_bit == 6'(FRAME_BITS - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_busy  <= 1'b0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= i_frame[FRAME_BITS-1];
    end else if (r_busy) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
        r_sck   <= 1'b1;
        r_mosi  <= r_shreg[FRAME_BITS-1];
      end else begin
        r_phase <= 1'b0;
        r_sck   <= 1'b0;
        if (w_last) begin
          r_busy <= 1'b0;
          r_bit  <= '0;
          r_mosi <= 1'b0;
        end else begin
          r_bit  <= r_bit + 6'd1;
          // Next bit is the one that moves into the MSB at this edge.
          r_mosi <= r_shreg[FRAME_BITS-2];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_start) begin
      r_shreg <= i_frame;
    end else if (r_busy && r_phase) begin
      r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
      r_rx_hist <= {r_rx_hist[5:0], i_miso};
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_sck     = r_sck;
  assign o_mosi    = r_mosi;
  assign o_rx_byte = {r_rx_hist, i_miso};

endmodule

// File: rtl/spi_sram_responder.sv
// spi_sram_responder
//   Wishbone byte slave that turns every access into one single-byte SPI
//   transaction on an external 23LC1024-class serial SRAM (SPI mode 0).
//   sram_config_i picks which chip select is driven; code 3 means no device
//   is fitted and the access is answered with a 1-cycle error.
//
//   Timeline for an accepted request sampled at edge E:
//     E      : request latched, frame built, engine start pulse registered
//     E+1    : chip select falls, first sck-low phase
//     E+81   : frame ends, chip select rises, ack registered
//     E+82   : back in IDLE, next request may be sampled
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   wbs_cyc_i/stb_i    Wishbone cycle / strobe
//   wbs_adr_i          byte address (zero-extended/truncated to 24 bits)
//   wbs_we_i           write enable
//   wbs_dat_i          write data
//   wbs_ack_o          1-cycle acknowledge
//   wbs_err_o          1-cycle error (no device selected)
//   wbs_rty_o          tied low
//   wbs_dat_o          read data, valid while ack is high
//   sram_config_i      chip select index 0..2, 3 = none
//   spi_sck_o          SPI clock (clk_i/2 while a frame is active)
//   spi_mosi_o         SPI data out, MSB first
//   spi_miso_i         SPI data in
//   spi_cs_n_o         active-low chip selects
module spi_sram_responder
  import levenshtein_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int NUM_CS     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0]    wbs_adr_i,
  input  logic                     wbs_we_i,
  input  logic [WB_DATA_WIDTH-1:0] wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic                     wbs_rty_o,
  output logic [WB_DATA_WIDTH-1:0] wbs_dat_o,
  input  logic [1:0]               sram_config_i,
  output logic                     spi_sck_o,
  output logic                     spi_mosi_o,
  input  logic                     spi_miso_i,
  output logic [NUM_CS-1:0]        spi_cs_n_o
);

  state_e                   r_state;
  logic                     r_start;
  logic                     r_abort;
  logic                     r_ack;
  logic                     r_err;
  logic [WB_DATA_WIDTH-1:0] r_dat;
  logic [NUM_CS-1:0]        r_cs_n;
  logic                     r_we;
  logic [1:0]               r_cs_idx;
  logic [FRAME_BITS-1:0]    r_frame;

  logic [SPI_ADDR_BITS-1:0] w_adr24;
  logic                     w_req;
  logic                     w_accept;
  logic                     w_reject;
  logic [NUM_CS-1:0]        w_cs_n_sel;
  logic                     w_eng_busy;
  logic                     w_eng_done;
  logic [7:0]               w_rx_byte;

  // The SRAM always takes a 24-bit address regardless of bus width.
  generate
    if (ADDR_WIDTH >= SPI_ADDR_BITS) begin : g_adr_trunc
      assign w_adr24 = wbs_adr_i[SPI_ADDR_BITS-1:0];
    end else begin : g_adr_ext
      assign w_adr24 = {{(SPI_ADDR_BITS-ADDR_WIDTH){1'b0}}, wbs_adr_i};
    end
  endgenerate

  // The !ack/!err terms stop a master that still holds stb during its own
  // response cycle from being seen as a second request.
  assign w_req    = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;
  assign w_accept = (r_state == ST_IDLE) & w_req & (sram_config_i != SRAM_CFG_NONE);
  assign w_reject = (r_state == ST_IDLE) & w_req & (sram_config_i == SRAM_CFG_NONE);

  always_comb begin
    w_cs_n_sel = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (r_cs_idx == 2'(i)) begin
        w_cs_n_sel[i] = 1'b0;
      end
    end
  end

  // Request attributes are frozen at acceptance so later bus or config
  // changes cannot disturb a frame in flight.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_frame  <= spi_frame(wbs_we_i, w_adr24, wbs_dat_i);
      r_we     <= wbs_we_i;
      r_cs_idx <= sram_config_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_cs_n  <= '1;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_reject) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_start <= 1'b1;
            r_abort <= 1'b0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Chip select drops together with the engine's first sck-low phase.
          if (r_start) begin
            r_cs_n <= w_cs_n_sel;
          end
          // A master that walks away mid-frame still gets a complete SPI
          // frame (keeps the SRAM in sync) but no response.
          if (!wbs_cyc_i && (r_start || w_eng_busy)) begin
            r_abort <= 1'b1;
          end
          if (w_eng_done) begin
            r_cs_n  <= '1;
            r_state <= ST_DONE;
            if (!r_abort && wbs_cyc_i) begin
              r_ack <= 1'b1;
              if (!r_we) begin
                r_dat <= w_rx_byte;
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  spi_shift_engine u_engine (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_start   (r_start),
    .i_frame   (r_frame),
    .o_busy    (w_eng_busy),
    .o_done    (w_eng_done),
    .o_sck     (spi_sck_o),
    .o_mosi    (spi_mosi_o),
    .i_miso    (spi_miso_i),
    .o_rx_byte (w_rx_byte)
  );

  assign wbs_ack_o  = r_ack;
  assign wbs_err_o  = r_err;
  assign wbs_rty_o  = 1'b0;
  assign wbs_dat_o  = r_dat;
  assign spi_cs_n_o = r_cs_n;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Testbench for spi_sram_responder: Wishbone master stimulus, a behavioural
// serial SRAM on the SPI pins, and scoreboards for bus responses and frames.
module tb_spi_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [23:0] adr;
  logic [7:0]  dat_i;
  logic [1:0]  cfg;
  logic        miso = 1'b0;
  logic        ack, err, rty;
  logic [7:0]  dat_o;
  logic        sck, mosi;
  logic [2:0]  cs_n;

  always #5 clk = ~clk;

  spi_sram_responder #(.ADDR_WIDTH(24), .NUM_CS(3)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_adr_i     (adr),
    .wbs_we_i      (we),
    .wbs_dat_i     (dat_i),
    .wbs_ack_o     (ack),
    .wbs_err_o     (err),
    .wbs_rty_o     (rty),
    .wbs_dat_o     (dat_o),
    .sram_config_i (cfg),
    .spi_sck_o     (sck),
    .spi_mosi_o    (mosi),
    .spi_miso_i    (miso),
    .spi_cs_n_o    (cs_n)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] dat;
    int         at;
  } resp_t;

  typedef struct {
    logic [2:0]  cs;
    int          nbits;
    logic [39:0] bits;
  } frm_t;

  resp_t rq[$];
  frm_t  fq[$];

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- serial SRAM model ----------------
  logic [7:0]  mem [0:255];
  logic        sck_q  = 1'b0;
  logic        cs_act = 1'b0;
  int          nb     = 0;
  logic [39:0] cap    = '0;
  logic [2:0]  cs_seen = 3'b111;
  logic [7:0]  outb   = '0;
  int          hi_cnt = 1000;
  int          last_gap = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'hA5;
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'hC3;
  end

  always @(negedge clk) begin
    frm_t e;
    if (&cs_n) begin
      if (cs_act) begin
        if (nb == 40 && cap[39:32] == 8'h02) mem[cap[15:8]] = cap[7:0];
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %0d bits %0h on cs %b, expected no frame", nb, cap, cs_seen);
        end else begin
          e = fq.pop_front();
          chk("frame_cs", 64'(cs_seen), 64'(e.cs));
          chk("frame_nbits", 64'(nb), 64'(e.nbits));
          chk("frame_bits", 64'(cap), 64'(e.bits));
        end
        cs_act = 1'b0;
      end
      hi_cnt++;
      if (sck && !sck_q) begin
        checks++;
        errors++;
        $display("FAIL sck_idle: sck rose with cs_n=%b, expected sck low", cs_n);
      end
    end else begin
      if (!cs_act) begin
        cs_act   = 1'b1;
        nb       = 0;
        cap      = '0;
        cs_seen  = 3'b111;
        last_gap = hi_cnt;
        hi_cnt   = 0;
      end
      cs_seen = cs_seen & cs_n;
      if (sck && !sck_q) begin
        cap = {cap[38:0], mosi};
        nb++;
      end else if (!sck && sck_q) begin
        if (nb == 32 && cap[31:24] == 8'h03) outb = mem[cap[7:0]];
        if (nb >= 32) begin
          miso = outb[7];
          outb = {outb[6:0], 1'b0};
        end
      end
    end
    sck_q = sck;
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    resp_t r;
    if (rst_n) begin
      if (ack && err) begin
        checks++;
        errors++;
        $display("FAIL ack_err_both: got ack=1 err=1, expected at most one");
      end
      if (ack || err) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got ack=%0b err=%0b, expected none", ack, err);
        end else begin
          r = rq.pop_front();
          chk("resp_is_err", 64'(err), 64'(r.is_err));
          chk("resp_cycle", 64'(cyc_cnt), 64'(r.at));
          if (!r.is_err) chk("resp_dat", 64'(dat_o), 64'(r.dat));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_resp();
    int n = 0;
    while (!(ack || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no ack/err after %0d cycles, expected one", n);
    end
  endtask

  task automatic do_access(input logic w, input logic [23:0] a, input logic [7:0] d,
                           input logic [1:0] c, input logic e_err, input logic [7:0] e_dat,
                           input logic [2:0] e_cs, input logic [39:0] e_frame, input logic keep_cyc);
    resp_t r;
    frm_t  f;
    @(negedge clk);
    r.is_err = e_err;
    r.dat    = e_dat;
    r.at     = cyc_cnt + (e_err ? 1 : 82);
    rq.push_back(r);
    if (!e_err) begin
      f.cs    = e_cs;
      f.nbits = 40;
      f.bits  = e_frame;
      fq.push_back(f);
    end
    we = w; adr = a; dat_i = d; cfg = c; cyc = 1'b1; stb = 1'b1;
    wait_resp();
    stb = 1'b0;
    if (!keep_cyc) cyc = 1'b0;
  endtask

  task automatic wait_bits(input int target);
    int n = 0;
    while (!(cs_act && nb >= target) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL bits_timeout: got %0d bits, expected %0d", nb, target);
    end
  endtask

  initial begin
    frm_t f;
    int   n;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_i = '0; cfg = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_rty", 64'(rty), 64'h0);
    chk("rst_dat", 64'(dat_o), 64'h00);
    chk("rst_sck", 64'(sck), 64'h0);
    chk("rst_mosi", 64'(mosi), 64'h0);
    chk("rst_cs_n", 64'(cs_n), 64'h7);
    rst_n = 1'b1;

    // write 5A @000400 on cs0; dat_o keeps its reset value 00
    do_access(1'b1, 24'h000400, 8'h5A, 2'd0, 1'b0, 8'h00, 3'b110, 40'h02_000400_5A, 1'b0);
    // read 000401 on cs1 -> A5
    do_access(1'b0, 24'h000401, 8'hFF, 2'd1, 1'b0, 8'hA5, 3'b101, 40'h03_000401_00, 1'b0);

    // no device: 1-cycle err, no SPI activity
    do_access(1'b1, 24'h000123, 8'hFF, 2'd3, 1'b1, 8'h00, 3'b111, 40'h0, 1'b0);
    chk("err_cs_n", 64'(cs_n), 64'h7);
    chk("err_sck", 64'(sck), 64'h0);
    @(negedge clk);
    chk("err_one_cycle", 64'(err), 64'h0);
    do_access(1'b0, 24'h000401, 8'h00, 2'd3, 1'b1, 8'h00, 3'b111, 40'h0, 1'b0);

    // back-to-back reads with cyc held: read back the earlier write, then cs2
    do_access(1'b0, 24'h000400, 8'h00, 2'd0, 1'b0, 8'h5A, 3'b110, 40'h03_000400_00, 1'b1);
    do_access(1'b0, 24'h000410, 8'h00, 2'd2, 1'b0, 8'h3C, 3'b011, 40'h03_000410_00, 1'b0);
    chk("cs_gap_min2", 64'(last_gap >= 2), 64'h1);

    // cyc dropped mid-frame: frame completes, no ack, dat_o unchanged
    f.cs = 3'b110; f.nbits = 40; f.bits = 40'h03_000411_00;
    fq.push_back(f);
    @(negedge clk);
    we = 1'b0; adr = 24'h000411; cfg = 2'd0; cyc = 1'b1; stb = 1'b1;
    wait_bits(10);
    cyc = 1'b0; stb = 1'b0;
    n = 0;
    while (cs_act && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drop_frame_end", 64'(cs_act), 64'h0);
    repeat (4) @(negedge clk);
    chk("drop_dat_hold", 64'(dat_o), 64'h3C);
    do_access(1'b0, 24'h000411, 8'h00, 2'd0, 1'b0, 8'hC3, 3'b110, 40'h03_000411_00, 1'b0);

    // reset 20 bits into a frame on cs2
    f.cs = 3'b011; f.nbits = 20; f.bits = 40'h03_000401_00 >> 20;
    fq.push_back(f);
    @(negedge clk);
    we = 1'b0; adr = 24'h000401; cfg = 2'd2; cyc = 1'b1; stb = 1'b1;
    wait_bits(20);
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", 64'(cs_n), 64'h7);
    chk("abort_sck", 64'(sck), 64'h0);
    chk("abort_ack", 64'(ack), 64'h0);
    rst_n = 1'b1;
    do_access(1'b0, 24'h000401, 8'h00, 2'd2, 1'b0, 8'hA5, 3'b011, 40'h03_000401_00, 1'b0);

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", 64'(rq.size()), 64'h0);
    chk("frame_queue_empty", 64'(fq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc_cnt);
    $fatal(1, "watchdog");
  end

endmodule
